// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw buttons and jump handshake in, conditioned controls out
// master: board/consumer side driving raw buttons and jump_ack
// slave: conditioner driving left/right/jump_req/jump_held
interface button_conditioner_if;
  logic btn_left_raw, btn_right_raw, btn_jump_raw, jump_ack;
  logic left, right, jump_req, jump_held;
  modport master (
    output btn_left_raw, btn_right_raw, btn_jump_raw, jump_ack,
    input  left, right, jump_req, jump_held
  );
  modport slave (
    input  btn_left_raw, btn_right_raw, btn_jump_raw, jump_ack,
    output left, right, jump_req, jump_held
  );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: sync, debounce and resolve raw buttons into movement controls
// vga_clock: sole clock; reset_n: synchronous active-low reset
// bus.btn_*_raw: async raw buttons; bus.jump_ack: consumer clears jump_req
// bus.left/right: resolved direction levels; bus.jump_req: held request; bus.jump_held: debounced jump
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1,
  parameter bit LR_POLICY         = 1'b1
) (
  input logic vga_clock,
  input logic reset_n,
  button_conditioner_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {DIR_NONE, DIR_L, DIR_R} dir_t;
  logic [2:0] w_norm, r_sync1, r_sync2, r_stable, r_prev, w_rise;
  logic [CW-1:0] r_cnt [3];
  dir_t r_dir, w_dir_nxt;
  logic r_jump_req, w_jump_req_nxt;
  // bit order {jump, right, left}; after this 1 always means pressed
  assign w_norm = {bus.btn_jump_raw, bus.btn_right_raw, bus.btn_left_raw} ^ {3{BUTTON_ACTIVE_LOW}};
  assign w_rise = r_stable & ~r_prev;
  always_ff @(posedge vga_clock) begin
    if (!reset_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_prev     <= '0;
      r_jump_req <= 1'b0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1    <= w_norm;
      r_sync2    <= r_sync1;
      r_prev     <= r_stable;
      r_jump_req <= w_jump_req_nxt;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_stable[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end
  always_ff @(posedge vga_clock) begin
    if (!reset_n) r_dir <= DIR_NONE;
    else r_dir <= w_dir_nxt;
  end
  // Rising edges take priority; a falling active direction hands over to the one still held
  always_comb begin
    w_dir_nxt = r_dir;
    if (w_rise[0] && w_rise[1]) w_dir_nxt = DIR_NONE;
    else if (w_rise[0]) w_dir_nxt = DIR_L;
    else if (w_rise[1]) w_dir_nxt = DIR_R;
    else if (!r_stable[0] && !r_stable[1]) w_dir_nxt = DIR_NONE;
    else if (r_dir == DIR_L && !r_stable[0]) w_dir_nxt = DIR_R;
    else if (r_dir == DIR_R && !r_stable[1]) w_dir_nxt = DIR_L;
  end
  // A fresh press outranks a simultaneous ack so the press is never lost
  assign w_jump_req_nxt = w_rise[2] | (r_jump_req & ~bus.jump_ack);
  assign bus.left      = LR_POLICY ? (r_dir == DIR_L) : r_prev[0];
  assign bus.right     = LR_POLICY ? (r_dir == DIR_R) : r_prev[1];
  assign bus.jump_req  = r_jump_req;
  assign bus.jump_held = r_prev[2];
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Sits directly upstream of the Mario movement stage; turns raw board push-buttons (left, right, jump) into clean, stable control levels.
- Synchronises each button into the vga_clock domain and debounces it with a per-channel counter.
- Resolves simultaneous left/right presses according to a fixed policy.
- Converts jump presses into a held request. The request stays up until the slow movement-tick consumer acknowledges it, so a press is never lost between movement ticks.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive vga_clock cycles a synchronised input must differ from its stable state before the stable state flips (10 ms at 25 MHz); minimum 2.
- BUTTON_ACTIVE_LOW, 1, 1 = raw buttons read 0 when pressed (board KEYs); 0 = active-high.
- LR_POLICY, 1, 0 = pass-through (left and right may both be 1); 1 = last-pressed wins.

Ports:
- vga_clock  input  1  sole clock, all logic on posedge
- reset_n  input  1  synchronous, active-low reset
- btn_left_raw  input  1  asynchronous raw left button
- btn_right_raw  input  1  asynchronous raw right button
- btn_jump_raw  input  1  asynchronous raw jump button
- jump_ack  input  1  consumer pulse (≥1 cycle) clearing jump_req
- left  output  1  conditioned left level to the movement stage
- right  output  1  conditioned right level to the movement stage
- jump_req  output  1  latched jump request
- jump_held  output  1  debounced jump level

Behaviour:
- Reset: all actions below happen when reset_n = 0 at a posedge.
  - Sync flops go to the released value (normalised 0).
  - Stable states and counters go to 0; last_dir goes to NONE.
  - All outputs go to 0.
  - A reset mid-debounce discards partial counts.
- Normalisation: each raw input is inverted when BUTTON_ACTIVE_LOW = 1. Internally, 1 always means pressed.
- Synchroniser: two flops per channel. sync2 is the synchronised sample.
- Debounce, per channel. Counter width is clog2(DEBOUNCE_CYCLES).
  - If sync2 == stable, the counter clears to 0.
  - If sync2 != stable and counter == DEBOUNCE_CYCLES-1, stable <= sync2 and the counter clears to 0.
  - Otherwise the counter increments.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles leaves stable unchanged.
- Latency: a raw transition held steady changes stable on the (2 + DEBOUNCE_CYCLES)th posedge after it is first sampled. Outputs are registered from stable, so they change one further posedge later.
- Left/right, LR_POLICY = 0:
  - left = stable_L; right = stable_R.
  - Both may be 1; the downstream stage treats that as its own reset/recentre case.
- Left/right, LR_POLICY = 1 (state machine, last_dir in {NONE, L, R}):
  - Rising edge of stable_L → last_dir = L. Rising edge of stable_R → last_dir = R.
  - Both rising edges in the same cycle → last_dir = NONE.
  - Falling edge of the active direction while the other is still held → switch to the other.
  - Both released → NONE.
  - left = (last_dir == L); right = (last_dir == R). Never both 1.
- Jump:
  - jump_held = stable_J.
  - Rising edge of stable_J sets jump_req.
  - jump_ack clears jump_req on the next posedge.
  - If jump_ack and a new rising edge occur in the same cycle, jump_req stays 1 (new press wins).
  - Holding jump does not re-arm; only a release followed by a new press sets jump_req again.
  - jump_ack while jump_req = 0 has no effect.
- Channels are fully independent; there is no shared counter.

Test Plan (DEBOUNCE_CYCLES = 4, BUTTON_ACTIVE_LOW = 1):
1. Reset: hold reset_n = 0 for 3 cycles with all raw = 0 (pressed) → left, right, jump_req and jump_held stay 0 throughout. After release with raw = 0 held, left rises at posedge 7 after release.
2. Glitch rejection: btn_left_raw 1→0 for 3 cycles, then back to 1 → left never asserts and the counter returns to 0. A 0 held for 10 cycles → left = 1 exactly 7 posedges after the first sampled 0.
3. LR_POLICY = 1: press left, then right 20 cycles later → left 1→0 and right 0→1 on the same posedge. Release right with left still held → left = 1, right = 0. Release both → both 0.
4. LR_POLICY = 0: press left and right together → both outputs 1 simultaneously.
5. Jump handshake: press jump and hold for 50 cycles → jump_req = 1 held with no ack. Pulse jump_ack for 1 cycle → jump_req = 0 next posedge and stays 0 while the button is still held. Release, then press again → jump_req = 1.
6. Ack/press collision: time jump_ack to the same cycle as the stable_J rising edge → jump_req = 1. Assert reset_n = 0 mid-debounce of jump → jump_req = 0 and no later assertion without a fresh full press.
